// File: rtl/cskipa_sched_pkg.sv
// -----------------------------------------------------------------------------
// cskipa_sched_pkg
// Shared constants and types for the round-robin scheduler in front of the
// 42-bit carry-skip adder.
//   NREQ     : number of requesters sharing the adder
//   WIDTH    : operand / sum width (fixed by the shared adder)
//   IDW      : width of a requester index
//   req_id_t : requester index type
// -----------------------------------------------------------------------------
package cskipa_sched_pkg;

   localparam int NREQ  = 4;
   localparam int WIDTH = 42;
   localparam int IDW   = $clog2(NREQ);

   typedef logic [IDW-1:0] req_id_t;

endpackage : cskipa_sched_pkg

// File: rtl/CSkipA_42bit.sv
// -----------------------------------------------------------------------------
// CSkipA_42bit
// Purely combinational 42-bit carry-skip adder, no carry-in.
// Seven 6-bit ripple blocks; a block whose bits all propagate forwards its
// incoming carry directly instead of waiting on its internal ripple.
// Ports:
//   i_a, i_b : 42-bit unsigned operands
//   o_sum    : (i_a + i_b) mod 2^42
//   o_cout   : carry-out of the addition
// -----------------------------------------------------------------------------
module CSkipA_42bit (
   input  logic [41:0] i_a,
   input  logic [41:0] i_b,
   output logic [41:0] o_sum,
   output logic        o_cout
);

   localparam int BLK  = 6;
   localparam int NBLK = 7;

   always_comb begin
      logic carry;
      logic blk_cin;
      logic blk_prop;
      logic p;
      logic g;

      carry    = 1'b0;
      blk_cin  = 1'b0;
      blk_prop = 1'b0;
      p        = 1'b0;
      g        = 1'b0;
      o_sum    = '0;

      for (int j = 0; j < NBLK; j++) begin
         blk_cin  = carry;
         blk_prop = 1'b1;
         for (int i = 0; i < BLK; i++) begin
            p                = i_a[j*BLK+i] ^ i_b[j*BLK+i];
            g                = i_a[j*BLK+i] & i_b[j*BLK+i];
            o_sum[j*BLK+i]   = p ^ carry;
            carry            = g | (p & carry);
            blk_prop         = blk_prop & p;
         end
         // Skip path: when every bit propagates, the block carry-out equals
         // its carry-in, so the ripple result is bypassed.
         if (blk_prop) begin
            carry = blk_cin;
         end
      end

      o_cout = carry;
   end

endmodule : CSkipA_42bit

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant selection. Search starts at i_ptr and moves
// upward with wrap; the first asserted request wins. No grant is issued when
// the result slot is not free.
// Ports:
//   i_req       : per-requester request valid
//   i_ptr       : index where the search starts
//   i_slot_free : result register can take a new result this cycle
//   o_gnt       : one-hot grant (all zero when nothing is granted)
//   o_gnt_idx   : encoded index of the first requester found from i_ptr
//   o_gnt_any   : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
   import cskipa_sched_pkg::*;
#(
   parameter int NREQ = cskipa_sched_pkg::NREQ,
   parameter int IDW  = cskipa_sched_pkg::IDW
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   input  logic            i_slot_free,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_gnt_idx,
   output logic            o_gnt_any
);

   logic           found;
   logic [IDW-1:0] found_idx;

   always_comb begin
      logic [IDW-1:0] k_idx;
      int             k;

      found     = 1'b0;
      found_idx = '0;
      k         = 0;
      k_idx     = '0;
      // Walk from the farthest offset down to offset 0 so that the candidate
      // closest to the pointer is the last one written and therefore wins.
      for (int off = NREQ - 1; off >= 0; off--) begin
         k     = (int'(i_ptr) + off) % NREQ;
         k_idx = IDW'(k);
         if (i_req[k_idx]) begin
            found     = 1'b1;
            found_idx = k_idx;
         end
      end
   end

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = found_idx;
      o_gnt_any = found && i_slot_free;
      if (o_gnt_any) begin
         o_gnt[found_idx] = 1'b1;
      end
   end

endmodule : rr_arbiter

// File: rtl/cskipa_rr_scheduler.sv
// -----------------------------------------------------------------------------
// cskipa_rr_scheduler
// Shares one CSkipA_42bit among NREQ requesters. One request is granted per
// cycle in round-robin order; its sum and carry-out land in a single-entry
// result register tagged with the requester index.
//
// Handshake: a request transfers in a cycle where i_req_valid[k] and
// o_req_ready[k] are both high; a result transfers in a cycle where
// o_res_valid and i_res_ready are both high. o_req_ready depends
// combinationally on i_req_valid, so requesters must not derive valid from
// ready, and must hold valid and operands stable until accepted.
//
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_req_valid         : per-requester request valid
//   o_req_ready         : per-requester accept, at most one bit high
//   i_req_a, i_req_b    : packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_res_valid         : result register holds a result
//   i_res_ready         : downstream takes the result
//   o_res_sum/o_res_cout: registered {cout,sum} = A + B
//   o_res_id            : requester that produced the result
//   o_accept_cnt        : number of accepted requests, wraps at 2^32
// -----------------------------------------------------------------------------
module cskipa_rr_scheduler
   import cskipa_sched_pkg::*;
#(
   parameter int NREQ  = cskipa_sched_pkg::NREQ,
   parameter int WIDTH = cskipa_sched_pkg::WIDTH,  // must match the shared adder (42)
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NREQ-1:0]       i_req_valid,
   output logic [NREQ-1:0]       o_req_ready,
   input  logic [NREQ*WIDTH-1:0] i_req_a,
   input  logic [NREQ*WIDTH-1:0] i_req_b,
   output logic                  o_res_valid,
   input  logic                  i_res_ready,
   output logic [WIDTH-1:0]      o_res_sum,
   output logic                  o_res_cout,
   output logic [IDW-1:0]        o_res_id,
   output logic [31:0]           o_accept_cnt
);

   // Result register and scheduler state
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_sum_q,   res_sum_d;
   logic             res_cout_q,  res_cout_d;
   logic [IDW-1:0]   res_id_q,    res_id_d;
   logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [31:0]      accept_cnt_q, accept_cnt_d;

   logic             slot_free;
   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic             accept;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   // A draining result frees the slot in the same cycle, so a refill can
   // overlap the drain.
   assign slot_free = !res_valid_q || i_res_ready;

   // Reset masks the slot so no ready is raised while i_rst is high.
   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req       (i_req_valid),
      .i_ptr       (rr_ptr_q),
      .i_slot_free (slot_free && !i_rst),
      .o_gnt       (gnt),
      .o_gnt_idx   (gnt_idx),
      .o_gnt_any   (accept)
   );

   assign o_req_ready = gnt;

   // Operand mux indexed by the encoded grant.
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_idx == IDW'(k)) begin
            op_a = i_req_a[k*WIDTH +: WIDTH];
            op_b = i_req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   CSkipA_42bit u_adder (
      .i_a    (op_a),
      .i_b    (op_b),
      .o_sum  (add_sum),
      .o_cout (add_cout)
   );

   always_comb begin
      res_valid_d  = res_valid_q;
      res_sum_d    = res_sum_q;
      res_cout_d   = res_cout_q;
      res_id_d     = res_id_q;
      rr_ptr_d     = rr_ptr_q;
      accept_cnt_d = accept_cnt_q;

      if (accept) begin
         res_valid_d  = 1'b1;
         res_sum_d    = add_sum;
         res_cout_d   = add_cout;
         res_id_d     = gnt_idx;
         rr_ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         accept_cnt_d = accept_cnt_q + 32'd1;
      end else if (res_valid_q && i_res_ready) begin
         // Drain only; data fields keep their last value.
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         res_valid_q  <= 1'b0;
         res_sum_q    <= '0;
         res_cout_q   <= 1'b0;
         res_id_q     <= '0;
         rr_ptr_q     <= '0;
         accept_cnt_q <= '0;
      end else begin
         res_valid_q  <= res_valid_d;
         res_sum_q    <= res_sum_d;
         res_cout_q   <= res_cout_d;
         res_id_q     <= res_id_d;
         rr_ptr_q     <= rr_ptr_d;
         accept_cnt_q <= accept_cnt_d;
      end
   end

   assign o_res_valid  = res_valid_q;
   assign o_res_sum    = res_sum_q;
   assign o_res_cout   = res_cout_q;
   assign o_res_id     = res_id_q;
   assign o_accept_cnt = accept_cnt_q;

endmodule : cskipa_rr_scheduler

// File: tb/tb_cskipa_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cskipa_rr_scheduler
// Self-checking bench for cskipa_rr_scheduler. A behavioural model (pointer,
// result register, counter) and a result queue are kept in the bench; every
// scenario task drives stimulus through cycle() and compares inline.
// -----------------------------------------------------------------------------
module tb_cskipa_rr_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 42;
   localparam int IDW   = 2;
   localparam int RW    = IDW + 1 + WIDTH;

   // ---------------- clock / reset / DUT ----------------
   logic                  clk = 1'b0;
   logic                  i_rst;
   logic [NREQ-1:0]       i_req_valid;
   logic [NREQ-1:0]       o_req_ready;
   logic [NREQ*WIDTH-1:0] i_req_a;
   logic [NREQ*WIDTH-1:0] i_req_b;
   logic                  o_res_valid;
   logic                  i_res_ready;
   logic [WIDTH-1:0]      o_res_sum;
   logic                  o_res_cout;
   logic [IDW-1:0]        o_res_id;
   logic [31:0]           o_accept_cnt;

   always #5 clk = ~clk;

   cskipa_rr_scheduler #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .IDW   (IDW)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_a      (i_req_a),
      .i_req_b      (i_req_b),
      .o_res_valid  (o_res_valid),
      .i_res_ready  (i_res_ready),
      .o_res_sum    (o_res_sum),
      .o_res_cout   (o_res_cout),
      .o_res_id     (o_res_id),
      .o_accept_cnt (o_accept_cnt)
   );

   // ---------------- reference model / scoreboard ----------------
   int               n_checks = 0;
   int               n_fail   = 0;
   logic             m_valid;
   logic [WIDTH-1:0] m_sum;
   logic             m_cout;
   logic [IDW-1:0]   m_id;
   int               m_ptr;
   logic [31:0]      m_cnt;
   logic [RW-1:0]    exp_q[$];

   function automatic logic [WIDTH-1:0] rnd_op();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         default: return t[WIDTH-1:0];
      endcase
   endfunction

   function automatic logic [NREQ*WIDTH-1:0] rnd_vec();
      logic [NREQ*WIDTH-1:0] v;
      for (int k = 0; k < NREQ; k++) v[k*WIDTH +: WIDTH] = rnd_op();
      return v;
   endfunction

   // One clock of stimulus. Inputs change at the falling edge; the ready
   // vector is sampled 1 time unit later, the model steps on the rising edge,
   // and registered outputs are observable 1 time unit after it.
   task automatic cycle(input logic rst, input logic [NREQ-1:0] v,
                        input logic [NREQ*WIDTH-1:0] a, input logic [NREQ*WIDTH-1:0] b,
                        input logic rr,
                        output logic [NREQ-1:0] obs_rdy, output logic [NREQ-1:0] exp_rdy,
                        output int g, output logic drained, output logic [RW-1:0] drained_val);
      logic [WIDTH:0] full;
      int             k;
      @(negedge clk);
      i_rst       = rst;
      i_req_valid = v;
      i_req_a     = a;
      i_req_b     = b;
      i_res_ready = rr;
      #1;
      obs_rdy     = o_req_ready;
      drained     = !rst && m_valid && rr;
      drained_val = {o_res_id, o_res_cout, o_res_sum};
      g           = -1;
      exp_rdy     = '0;
      if (!rst && (!m_valid || rr)) begin
         for (int off = 0; off < NREQ; off++) begin
            k = (m_ptr + off) % NREQ;
            if (g < 0 && v[k]) g = k;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = '0; m_ptr = 0; m_cnt = '0;
         exp_q.delete();
      end else if (g >= 0) begin
         full    = {1'b0, a[g*WIDTH +: WIDTH]} + {1'b0, b[g*WIDTH +: WIDTH]};
         m_sum   = full[WIDTH-1:0];
         m_cout  = full[WIDTH];
         m_id    = IDW'(g);
         m_valid = 1'b1;
         m_ptr   = (g + 1) % NREQ;
         m_cnt   = m_cnt + 32'd1;
         exp_q.push_back({m_id, m_cout, m_sum});
      end else if (m_valid && rr) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   // scratch outputs of cycle()
   logic [NREQ-1:0]  obs_rdy, exp_rdy;
   int               gnt;
   logic             drained;
   logic [RW-1:0]    drained_val;

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, '1, rnd_vec(), rnd_vec(), 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
         n_checks++; if (obs_rdy !== '0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", obs_rdy); end
         n_checks++; if (o_res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_res_valid); end
         n_checks++; if (o_res_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", o_res_sum); end
         n_checks++; if (o_res_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", o_res_cout); end
         n_checks++; if (o_res_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", o_res_id); end
         n_checks++; if (o_accept_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", o_accept_cnt); end
      end
   endtask

   task automatic test_single();
      logic [NREQ*WIDTH-1:0] a, b;
      a = rnd_vec(); b = rnd_vec();
      a[2*WIDTH +: WIDTH] = '1;
      b[2*WIDTH +: WIDTH] = 42'd1;
      cycle(1'b0, 4'b0100, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", obs_rdy); end
      n_checks++; if (o_res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", o_res_valid); end
      n_checks++; if (o_res_sum !== '0) begin n_fail++; $display("FAIL single_sum: got %h expected 0", o_res_sum); end
      n_checks++; if (o_res_cout !== 1'b1) begin n_fail++; $display("FAIL single_cout: got %b expected 1", o_res_cout); end
      n_checks++; if (o_res_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d expected 2", o_res_id); end
      n_checks++; if (o_accept_cnt !== 32'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", o_accept_cnt); end
      // drain with nothing requesting: valid drops, data holds
      cycle(1'b0, 4'b0000, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b0000) begin n_fail++; $display("FAIL drain_ready: got %b expected 0000", obs_rdy); end
      n_checks++; if (o_res_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", o_res_valid); end
      n_checks++; if ({o_res_id, o_res_cout, o_res_sum} !== {2'd2, 1'b1, 42'd0}) begin n_fail++;
         $display("FAIL drain_hold: got id=%0d cout=%b sum=%h expected id=2 cout=1 sum=0", o_res_id, o_res_cout, o_res_sum); end
   endtask

   task automatic test_round_robin();
      cycle(1'b1, '0, '0, '0, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, '1, rnd_vec(), rnd_vec(), 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
         n_checks++; if (obs_rdy !== 4'(1 << (i % NREQ))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, obs_rdy, 4'(1 << (i % NREQ))); end
         n_checks++; if (o_res_id !== IDW'(i % NREQ)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, o_res_id, i % NREQ); end
         n_checks++; if ({o_res_cout, o_res_sum} !== {m_cout, m_sum}) begin n_fail++;
            $display("FAIL rr_sum[%0d]: got %b/%h expected %b/%h", i, o_res_cout, o_res_sum, m_cout, m_sum); end
      end
      n_checks++; if (o_accept_cnt !== 32'd8) begin n_fail++; $display("FAIL rr_cnt: got %0d expected 8", o_accept_cnt); end
   endtask

   task automatic test_backpressure();
      logic [NREQ*WIDTH-1:0] a, b;
      logic [WIDTH-1:0]      held_sum;
      logic [IDW-1:0]        held_id;
      a = rnd_vec(); b = rnd_vec();
      // pointer is 0 after the round-robin run: this loads requester 0
      cycle(1'b0, '1, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      held_sum = m_sum; held_id = m_id;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, '1, a, b, 1'b0, obs_rdy, exp_rdy, gnt, drained, drained_val);
         n_checks++; if (obs_rdy !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, obs_rdy); end
         n_checks++; if (o_res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, o_res_valid); end
         n_checks++; if (o_res_sum !== held_sum || o_res_id !== held_id) begin n_fail++;
            $display("FAIL stall_hold[%0d]: got id=%0d sum=%h expected id=%0d sum=%h", i, o_res_id, o_res_sum, held_id, held_sum); end
      end
      // release: drain and refill in the same cycle, pointer still at 1
      cycle(1'b0, '1, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b0010) begin n_fail++; $display("FAIL release_ready: got %b expected 0010", obs_rdy); end
      n_checks++; if (o_res_valid !== 1'b1 || o_res_id !== 2'd1) begin n_fail++;
         $display("FAIL release_refill: got valid=%b id=%0d expected valid=1 id=1", o_res_valid, o_res_id); end
      n_checks++; if ({o_res_cout, o_res_sum} !== {m_cout, m_sum}) begin n_fail++;
         $display("FAIL release_sum: got %b/%h expected %b/%h", o_res_cout, o_res_sum, m_cout, m_sum); end
      cycle(1'b0, '0, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
   endtask

   task automatic test_sparse();
      logic [NREQ*WIDTH-1:0] a, b;
      cycle(1'b1, '0, '0, '0, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      a = rnd_vec(); b = rnd_vec();
      cycle(1'b0, 4'b0010, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);  // pointer -> 2
      a[1*WIDTH +: WIDTH] = 42'h155_5555_5555; b[1*WIDTH +: WIDTH] = 42'h2AA_AAAA_AAAA;
      a[3*WIDTH +: WIDTH] = 42'h155_5555_5555; b[3*WIDTH +: WIDTH] = 42'h2AA_AAAA_AAAA;
      cycle(1'b0, 4'b1010, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b1000) begin n_fail++; $display("FAIL sparse_ready0: got %b expected 1000", obs_rdy); end
      n_checks++; if (o_res_id !== 2'd3) begin n_fail++; $display("FAIL sparse_id0: got %0d expected 3", o_res_id); end
      n_checks++; if ({o_res_cout, o_res_sum} !== {1'b0, 42'h3FF_FFFF_FFFF}) begin n_fail++;
         $display("FAIL sparse_sum0: got %b/%h expected 0/3ffffffffff", o_res_cout, o_res_sum); end
      cycle(1'b0, 4'b0010, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b0010) begin n_fail++; $display("FAIL sparse_ready1: got %b expected 0010", obs_rdy); end
      n_checks++; if (o_res_id !== 2'd1) begin n_fail++; $display("FAIL sparse_id1: got %0d expected 1", o_res_id); end
      n_checks++; if ({o_res_cout, o_res_sum} !== {1'b0, 42'h3FF_FFFF_FFFF}) begin n_fail++;
         $display("FAIL sparse_sum1: got %b/%h expected 0/3ffffffffff", o_res_cout, o_res_sum); end
   endtask

   task automatic test_mid_stall_reset();
      logic [NREQ*WIDTH-1:0] a, b;
      a = rnd_vec(); b = rnd_vec();
      cycle(1'b0, '1, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      cycle(1'b0, '1, a, b, 1'b0, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b0000 || o_res_valid !== 1'b1) begin n_fail++;
         $display("FAIL msr_stall: got ready=%b valid=%b expected ready=0000 valid=1", obs_rdy, o_res_valid); end
      cycle(1'b1, '1, a, b, 1'b0, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b0000) begin n_fail++; $display("FAIL msr_ready: got %b expected 0000", obs_rdy); end
      n_checks++; if (o_res_valid !== 1'b0) begin n_fail++; $display("FAIL msr_valid: got %b expected 0", o_res_valid); end
      n_checks++; if (o_accept_cnt !== 32'd0) begin n_fail++; $display("FAIL msr_cnt: got %0d expected 0", o_accept_cnt); end
      cycle(1'b0, '1, a, b, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      n_checks++; if (obs_rdy !== 4'b0001) begin n_fail++; $display("FAIL msr_first_ready: got %b expected 0001", obs_rdy); end
      n_checks++; if (o_res_valid !== 1'b1 || o_res_id !== 2'd0) begin n_fail++;
         $display("FAIL msr_first_id: got valid=%b id=%0d expected valid=1 id=0", o_res_valid, o_res_id); end
   endtask

   task automatic test_random();
      logic [NREQ-1:0]       pend;
      logic [NREQ*WIDTH-1:0] ra, rb;
      int                    wait_acc[NREQ];
      int                    accepts;
      int                    cyc;
      logic                  rr;
      logic [RW-1:0]         exp_val;
      cycle(1'b1, '0, '0, '0, 1'b1, obs_rdy, exp_rdy, gnt, drained, drained_val);
      pend = '0; ra = '0; rb = '0; accepts = 0; cyc = 0;
      for (int k = 0; k < NREQ; k++) wait_acc[k] = 0;
      while (accepts < 10000 && cyc < 60000) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!pend[k] && $urandom_range(0, 2) == 0) begin
               pend[k] = 1'b1;
               ra[k*WIDTH +: WIDTH] = rnd_op();
               rb[k*WIDTH +: WIDTH] = rnd_op();
               wait_acc[k] = 0;
            end
         end
         rr = ($urandom_range(0, 3) != 0);
         cycle(1'b0, pend, ra, rb, rr, obs_rdy, exp_rdy, gnt, drained, drained_val);
         cyc++;
         n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, obs_rdy, exp_rdy); end
         n_checks++; if ($countones(obs_rdy) > 1) begin n_fail++; $display("FAIL rnd_onehot@%0d: got %b expected at most one bit", cyc, obs_rdy); end
         if (drained) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rnd_drain@%0d: got a drain expected none queued", cyc);
            end else begin
               exp_val = exp_q.pop_front();
               if (drained_val !== exp_val) begin n_fail++; $display("FAIL rnd_drain@%0d: got %h expected %h", cyc, drained_val, exp_val); end
            end
         end
         n_checks++; if (o_res_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, o_res_valid, m_valid); end
         n_checks++; if ({o_res_id, o_res_cout, o_res_sum} !== {m_id, m_cout, m_sum}) begin n_fail++;
            $display("FAIL rnd_result@%0d: got id=%0d %b/%h expected id=%0d %b/%h", cyc, o_res_id, o_res_cout, o_res_sum, m_id, m_cout, m_sum); end
         n_checks++; if (o_accept_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", cyc, o_accept_cnt, m_cnt); end
         if (gnt >= 0) begin
            n_checks++; if (wait_acc[gnt] > NREQ - 1) begin n_fail++;
               $display("FAIL rnd_starve: got %0d other accepts before requester %0d expected at most %0d", wait_acc[gnt], gnt, NREQ - 1); end
            pend[gnt] = 1'b0;
            for (int k = 0; k < NREQ; k++) if (pend[k]) wait_acc[k]++;
            accepts++;
         end
      end
      n_checks++; if (accepts < 10000) begin n_fail++; $display("FAIL rnd_budget: got %0d accepts expected 10000", accepts); end
   endtask

   initial begin
      i_rst = 1'b1; i_req_valid = '0; i_req_a = '0; i_req_b = '0; i_res_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_sparse();
      test_mid_stall_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_cskipa_rr_scheduler

// File: doc/cskipa_rr_scheduler.md
# cskipa_rr_scheduler

Round-robin scheduler sharing one 42-bit carry-skip adder (`CSkipA_42bit`) among `NREQ` independent requesters. Each requester presents an operand pair under a valid/ready handshake. The scheduler grants one requester per cycle and drives the shared adder. It captures sum and carry-out into a single-entry output register that is tagged with the requester ID and drained under downstream backpressure. It sits between the adder-consuming client blocks and the adder datapath, and is the only instantiator of the shared adder.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `WIDTH`, 42, adder width; must equal the width of the shared adder.
- `IDW`, `$clog2(NREQ)`, requester ID width.

Ports:
- `i_clk`, input, 1, single clock; all state updates on the rising edge.
- `i_rst`, input, 1, reset, synchronous and active-high.
- `i_req_valid`, input, NREQ, per-requester request valid.
- `o_req_ready`, output, NREQ, per-requester accept; at most one bit high.
- `i_req_a`, input, NREQ*WIDTH, operand A; requester k occupies bits [k*WIDTH +: WIDTH].
- `i_req_b`, input, NREQ*WIDTH, operand B; same packing as `i_req_a`.
- `o_res_valid`, output, 1, result register holds a valid result.
- `i_res_ready`, input, 1, downstream accepts the result.
- `o_res_sum`, output, WIDTH, registered sum, i.e. (A+B) mod 2^WIDTH.
- `o_res_cout`, output, 1, registered carry-out of A+B.
- `o_res_id`, output, IDW, index of the requester that produced the result.
- `o_accept_cnt`, output, 32, count of accepted requests; wraps modulo 2^32.

## Operation
- `slot_free` = !`o_res_valid` || `i_res_ready`. This allows a drain and a refill in the same cycle.
- Grant selection:
  - Search starts at pointer `rr_ptr` (IDW bits) and proceeds in increasing index with wrap.
  - The first k with `i_req_valid[k]` = 1 is granted.
- `o_req_ready[g]` = `slot_free` && any `i_req_valid`, where g is the granted requester. All other ready bits are 0.
  - Ready depends combinationally on `i_req_valid`.
  - Requesters must not make valid depend on ready.
- Accept: the cycle where `i_req_valid[g]` && `o_req_ready[g]`. On the next edge:
  - `o_res_sum`/`o_res_cout` ← adder(`i_req_a[g]`, `i_req_b[g]`).
  - `o_res_id` ← g, and `o_res_valid` ← 1.
  - `rr_ptr` ← (g+1) mod NREQ; `o_accept_cnt` increments.
- Drain without accept (`o_res_valid` && `i_res_ready`, no accept): `o_res_valid` ← 0. The data fields hold their last value.
- Stall (`o_res_valid` && !`i_res_ready`): the result register and `rr_ptr` hold, and all `o_req_ready` = 0.
- No request valid: `rr_ptr` holds.
- Fairness: a continuously-valid requester is accepted within NREQ accepts.
- Arithmetic: unsigned WIDTH-bit add with no carry-in. The carry is `o_res_cout`, so {`o_res_cout`,`o_res_sum`} = A+B exactly.
- Requesters must hold valid and operands stable until accepted. The scheduler does not check this.

## Timing
- Reset values: `o_res_valid`=0, `o_res_sum`=0, `o_res_cout`=0, `o_res_id`=0, `rr_ptr`=0, `o_accept_cnt`=0.
- During reset, `o_req_ready`=0 regardless of inputs.
- Reset asserted mid-operation discards any held result. The first post-reset grant starts from requester 0.
- Latency: result valid one cycle after accept. Sustained throughput is one add per cycle while `i_res_ready`=1.
- The adder path is combinational from the muxed operands to the result register. The whole path (operand mux + adder) must close within one cycle.
- `o_accept_cnt` wrap: 0xFFFFFFFF + 1 → 0, with no flag.

## Structure
- Shared package `cskipa_sched_pkg`: `NREQ`, `WIDTH`, `IDW`, and the typedef `req_id_t` (logic [IDW-1:0]).
- Sub-module `rr_arbiter`:
  - Inputs: requests, `rr_ptr`, `slot_free`.
  - Outputs: one-hot grant and the encoded grant index.
  - Purely combinational; the pointer register lives in the top.
- One `CSkipA_42bit` instance, fed by an NREQ:1 operand mux indexed by grant.

## Test plan
- Reset then single request: assert reset, release; requester 2 sends A=0x3FF_FFFF_FFFF (all ones), B=1 → next cycle `o_res_valid`=1, sum=0, cout=1, id=2.
- All four valid continuously with `i_res_ready`=1 → accepts in order 0,1,2,3,0…; `o_accept_cnt`=8 after 8 cycles.
- Backpressure: hold `i_res_ready`=0 for 5 cycles with a result pending → result, id and `rr_ptr` stable, all `o_req_ready`=0; release → drain and refill in the same cycle.
- Sparse requests: only requesters 1 and 3 valid, `rr_ptr`=2 → grant 3 then 1; A=0x155_5555_5555, B=0x2AA_AAAA_AAAA → sum=0x3FF_FFFF_FFFF, cout=0.
- Mid-stall reset: result pending and stalled, assert `i_rst` → next cycle `o_res_valid`=0 and `o_accept_cnt`=0; the first grant after release goes to requester 0.
- Random 10k adds against the reference model {cout,sum}=A+B, with random valid/ready → no mismatch, no double accept, starvation bound ≤ NREQ holds.
